// File: rtl/mc_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I core: FSM states, opcodes
// and the mux/ALU select codes driven by the main control FSM.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_imm_src_dec.sv
// Opcode to immediate-format decoder; shared with the pipelined core's decode stage.
module mc_imm_src_dec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle RV32I core (lw, sw, R, I, beq, jal).
// Optional handshaking memory support via macro MC_MAIN_FSM_MEM_READY_EN.
module mc_main_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
`ifdef MC_MAIN_FSM_MEM_READY_EN
  input  logic       mem_ready,
`endif
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_e state_q, state_d;
  logic   mem_rdy;
  logic   pc_update;
  logic   branch;

`ifdef MC_MAIN_FSM_MEM_READY_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (mem_rdy) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      // DECODE precomputes the branch target into ALUOut
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal_op = 1'b1;
            state_d    = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      // Link value PC+4 comes from OldPC+4; PC takes the target held in ALUOut
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    pc_write = pc_update | (branch & zero);

    // Reset aborts the instruction: no strobes, selects parked at FETCH values
    if (!rst_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_FOUR;
      alu_op     = ALUOP_ADD;
      result_src = RES_ALURESULT;
    end
  end

  mc_imm_src_dec u_imm_src_dec (
    .op      (op),
    .imm_src (imm_src)
  );

  assign state_o = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Self-checking bench for mc_main_fsm: directed vector table, hand sequences for
// reset abort / HALT / mem_ready stalls, and randomized instruction streams.
module tb_mc_main_fsm;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = T_R;
  logic       zero = 1'b0;
  logic       mem_ready_drv = 1'b1;
`ifdef MC_MAIN_FSM_MEM_READY_EN
  logic       mem_ready = 1'b1;
`endif

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [3:0] state_o;

  logic       h_pc_write, h_adr_src, h_mem_write, h_ir_write, h_reg_write, h_illegal_op;
  logic [1:0] h_result_src, h_alu_src_a, h_alu_src_b, h_alu_op, h_imm_src;
  logic [3:0] h_state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_main_fsm #(.ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
`ifdef MC_MAIN_FSM_MEM_READY_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .reg_write(reg_write), .illegal_op(illegal_op), .state_o(state_o)
  );

  mc_main_fsm #(.ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
`ifdef MC_MAIN_FSM_MEM_READY_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(h_pc_write), .adr_src(h_adr_src), .mem_write(h_mem_write), .ir_write(h_ir_write),
    .result_src(h_result_src), .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .alu_op(h_alu_op),
    .imm_src(h_imm_src), .reg_write(h_reg_write), .illegal_op(h_illegal_op), .state_o(h_state_o)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, mw, rw, ill, adr;
    logic [1:0] res, srca, srcb, alu, imm;
  } exp_t;

  typedef struct packed {
    logic       rn;
    logic [6:0] op;
    logic       z;
    exp_t       e;
  } vec_t;

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == T_SW)  return 2'b01;
    if (o == T_BEQ) return 2'b10;
    if (o == T_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit known(input logic [6:0] o);
    return (o == T_LW) || (o == T_SW) || (o == T_R) || (o == T_I) || (o == T_BEQ) || (o == T_JAL);
  endfunction

  // Expected outputs from the per-state signal list; s is the current state number
  function automatic exp_t model(input int s, input logic [6:0] o, input logic z, input logic rn);
    exp_t e;
    e     = '0;
    e.st  = 4'(s);
    e.imm = imm_of(o);
    if (!rn) begin
      e.srcb = 2'b10;
      e.res  = 2'b10;
      return e;
    end
    case (s)
      0:  begin e.irw = 1; e.pcw = 1; e.srcb = 2'b10; e.res = 2'b10; end
      1:  begin e.srca = 2'b01; e.srcb = 2'b01; e.ill = !known(o); end
      2:  begin e.srca = 2'b10; e.srcb = 2'b01; end
      3:  begin e.adr = 1; end
      4:  begin e.res = 2'b01; e.rw = 1; end
      5:  begin e.adr = 1; e.mw = 1; end
      6:  begin e.srca = 2'b10; e.alu = 2'b10; end
      7:  begin e.srca = 2'b10; e.srcb = 2'b01; e.alu = 2'b10; end
      8:  begin e.rw = 1; end
      9:  begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1; end
      10: begin e.srca = 2'b10; e.alu = 2'b01; e.pcw = z; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input exp_t e);
    checkOutput({tag, ".state"},      8'(state_o),    8'(e.st));
    checkOutput({tag, ".pc_write"},   8'(pc_write),   8'(e.pcw));
    checkOutput({tag, ".ir_write"},   8'(ir_write),   8'(e.irw));
    checkOutput({tag, ".mem_write"},  8'(mem_write),  8'(e.mw));
    checkOutput({tag, ".reg_write"},  8'(reg_write),  8'(e.rw));
    checkOutput({tag, ".illegal_op"}, 8'(illegal_op), 8'(e.ill));
    checkOutput({tag, ".adr_src"},    8'(adr_src),    8'(e.adr));
    checkOutput({tag, ".result_src"}, 8'(result_src), 8'(e.res));
    checkOutput({tag, ".alu_src_a"},  8'(alu_src_a),  8'(e.srca));
    checkOutput({tag, ".alu_src_b"},  8'(alu_src_b),  8'(e.srcb));
    checkOutput({tag, ".alu_op"},     8'(alu_op),     8'(e.alu));
    checkOutput({tag, ".imm_src"},    8'(imm_src),    8'(e.imm));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later
  task automatic applyStimulus(input logic rn, input logic [6:0] o, input logic z);
    @(negedge clk);
    rst_n = rn;
    op    = o;
    zero  = z;
`ifdef MC_MAIN_FSM_MEM_READY_EN
    mem_ready = mem_ready_drv;
`endif
    #1;
  endtask

  task automatic resetBoth();
    applyStimulus(1'b0, T_R, 1'b0);
    applyStimulus(1'b0, T_R, 1'b0);
  endtask

  vec_t vecs[$];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p[$];
    logic [6:0] o;
    logic z;
    string tag;

    // fields: rn op z | st pcw irw mw rw ill adr res srca srcb alu imm
    vecs.push_back('{1'b0, T_R,   1'b0, '{4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,2'd2,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_LW,  1'b0, '{4'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,2'd2,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_LW,  1'b0, '{4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd1,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_LW,  1'b0, '{4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd1,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_LW,  1'b0, '{4'd3, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0,2'd0,2'd0,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_LW,  1'b0, '{4'd4, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd1,2'd0,2'd0,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_SW,  1'b0, '{4'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,2'd2,2'd0,2'd1}});
    vecs.push_back('{1'b1, T_SW,  1'b0, '{4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd1,2'd0,2'd1}});
    vecs.push_back('{1'b1, T_SW,  1'b0, '{4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd1,2'd0,2'd1}});
    vecs.push_back('{1'b1, T_SW,  1'b0, '{4'd5, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 2'd0,2'd0,2'd0,2'd0,2'd1}});
    vecs.push_back('{1'b1, T_BEQ, 1'b1, '{4'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,2'd2,2'd0,2'd2}});
    vecs.push_back('{1'b1, T_BEQ, 1'b1, '{4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd1,2'd0,2'd2}});
    vecs.push_back('{1'b1, T_BEQ, 1'b1, '{4'd10,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd0,2'd1,2'd2}});
    vecs.push_back('{1'b1, T_BEQ, 1'b0, '{4'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,2'd2,2'd0,2'd2}});
    vecs.push_back('{1'b1, T_BEQ, 1'b0, '{4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd1,2'd0,2'd2}});
    vecs.push_back('{1'b1, T_BEQ, 1'b0, '{4'd10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd0,2'd1,2'd2}});
    vecs.push_back('{1'b1, T_JAL, 1'b0, '{4'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,2'd2,2'd0,2'd3}});
    vecs.push_back('{1'b1, T_JAL, 1'b0, '{4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd1,2'd0,2'd3}});
    vecs.push_back('{1'b1, T_JAL, 1'b0, '{4'd9, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd2,2'd0,2'd3}});
    vecs.push_back('{1'b1, T_JAL, 1'b0, '{4'd8, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0,2'd3}});
    vecs.push_back('{1'b1, T_I,   1'b0, '{4'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,2'd2,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_I,   1'b0, '{4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd1,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_I,   1'b0, '{4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd1,2'd2,2'd0}});
    vecs.push_back('{1'b1, T_I,   1'b0, '{4'd8, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_BAD, 1'b0, '{4'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,2'd2,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_BAD, 1'b0, '{4'd1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'd0,2'd1,2'd1,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_R,   1'b0, '{4'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,2'd2,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_R,   1'b0, '{4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd1,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_R,   1'b0, '{4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd0,2'd2,2'd0}});
    vecs.push_back('{1'b1, T_R,   1'b0, '{4'd8, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0,2'd0}});
    vecs.push_back('{1'b1, T_R,   1'b0, '{4'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,2'd2,2'd0,2'd0}});

    $display("[TB] directed vector table");
    applyStimulus(1'b0, T_R, 1'b0);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rn, vecs[i].op, vecs[i].z);
      checkAll($sformatf("vec%0d", i), vecs[i].e);
    end

    $display("[TB] reset aborting a store in MEMWRITE");
    resetBoth();
    applyStimulus(1'b1, T_SW, 1'b0);
    applyStimulus(1'b1, T_SW, 1'b0);
    applyStimulus(1'b1, T_SW, 1'b0);
    applyStimulus(1'b0, T_SW, 1'b0);
    checkAll("abort_sw", model(5, T_SW, 1'b0, 1'b0));
    applyStimulus(1'b1, T_SW, 1'b0);
    checkAll("after_abort", model(0, T_SW, 1'b0, 1'b1));

    $display("[TB] illegal opcode with ILLEGAL_HALT=1");
    resetBoth();
    applyStimulus(1'b1, T_BAD, 1'b0);
    applyStimulus(1'b1, T_BAD, 1'b0);
    checkOutput("halt.decode_ill", 8'(h_illegal_op), 8'd1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, (k == 1) ? T_LW : T_BAD, 1'b1);
      checkOutput($sformatf("halt.state%0d", k), 8'(h_state_o), 8'd11);
      checkOutput($sformatf("halt.strobes%0d", k),
                  8'({h_pc_write, h_ir_write, h_mem_write, h_reg_write, h_illegal_op}), 8'd0);
      if (k == 0) checkOutput("nohalt.back_to_fetch", 8'(state_o), 8'd0);
    end
    applyStimulus(1'b0, T_BAD, 1'b0);
    applyStimulus(1'b1, T_R, 1'b0);
    checkOutput("halt.released", 8'(h_state_o), 8'd0);

`ifdef MC_MAIN_FSM_MEM_READY_EN
    $display("[TB] mem_ready stall in FETCH");
    resetBoth();
    mem_ready_drv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, T_R, 1'b0);
      checkOutput($sformatf("stall.state%0d", k), 8'(state_o), 8'd0);
      checkOutput($sformatf("stall.ir_write%0d", k), 8'(ir_write), 8'd0);
      checkOutput($sformatf("stall.pc_write%0d", k), 8'(pc_write), 8'd0);
    end
    mem_ready_drv = 1'b1;
    applyStimulus(1'b1, T_R, 1'b0);
    checkOutput("stall.release_ir", 8'(ir_write), 8'd1);
    applyStimulus(1'b1, T_R, 1'b0);
    checkOutput("stall.decode", 8'(state_o), 8'd1);
`endif

    // Random instruction streams: each opcode maps to its expected state path
    $display("[TB] randomized instruction stream");
    resetBoth();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 6))
        0: o = T_LW;
        1: o = T_SW;
        2: o = T_R;
        3: o = T_I;
        4: o = T_BEQ;
        5: o = T_JAL;
        default: begin
          o = 7'($urandom);
          while (known(o)) o = 7'($urandom);
        end
      endcase
      if      (o == T_LW)  p = '{0, 1, 2, 3, 4};
      else if (o == T_SW)  p = '{0, 1, 2, 5};
      else if (o == T_R)   p = '{0, 1, 6, 8};
      else if (o == T_I)   p = '{0, 1, 7, 8};
      else if (o == T_BEQ) p = '{0, 1, 10};
      else if (o == T_JAL) p = '{0, 1, 9, 8};
      else                 p = '{0, 1};
      for (int k = 0; k < p.size(); k++) begin
        z = 1'($urandom);
        tag = $sformatf("rnd%0d_op%02h_s%0d", n, o, p[k]);
        if ($urandom_range(0, 39) == 0) begin
          applyStimulus(1'b0, o, z);
          checkAll({tag, "_rst"}, model(p[k], o, z, 1'b0));
          break;
        end
        applyStimulus(1'b1, o, z);
        checkAll(tag, model(p[k], o, z, 1'b1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
